otp_seq_ctrl: RTL and testbench

Sequencer for the OTP macro behind the memtop xbus/register file. It generates the macro's csb/strobe/load/pgenb/vddqsw/addr timing for three operations: single-word read, per-bit program, and power-up autoload. Autoload copies every OTP word into the shadow registers via a one-cycle write port. Requests come from the reg05 read/program enables; the block runs on sys_clk (200 MHz).

---
 rtl/otp_seq_pkg.sv | 37 +++
 rtl/otp_seq_timer.sv | 25 ++
 rtl/otp_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_otp_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_seq_pkg.sv
// Shared state codes, default timing and address helpers for the OTP sequencer.
package otp_seq_pkg;

    localparam int unsigned T_SU_DEF = 2;
    localparam int unsigned T_RD_DEF = 4;
    localparam int unsigned T_HD_DEF = 2;
    localparam int unsigned T_PG_DEF = 1000;
    localparam int unsigned T_VQ_DEF = 20;

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [ST_W-1:0] ST_RD_SU    = 4'd1;
    localparam logic [ST_W-1:0] ST_RD_STB   = 4'd2;
    localparam logic [ST_W-1:0] ST_RD_HD    = 4'd3;
    localparam logic [ST_W-1:0] ST_AL_SU    = 4'd4;
    localparam logic [ST_W-1:0] ST_AL_STB   = 4'd5;
    localparam logic [ST_W-1:0] ST_AL_HD    = 4'd6;
    localparam logic [ST_W-1:0] ST_AL_WR    = 4'd7;
    localparam logic [ST_W-1:0] ST_PG_VQ_UP = 4'd8;
    localparam logic [ST_W-1:0] ST_PG_SU    = 4'd9;
    localparam logic [ST_W-1:0] ST_PG_STB   = 4'd10;
    localparam logic [ST_W-1:0] ST_PG_NEXT  = 4'd11;
    localparam logic [ST_W-1:0] ST_PG_VQ_DN = 4'd12;

    function automatic int unsigned bit_idx_w(input int unsigned data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    // Macro address is {word, bit}; bit is zero for reads.
    function automatic logic [31:0] pack_otp_addr(input logic [31:0] word,
                                                  input logic [31:0] bit_idx,
                                                  input int unsigned bw);
        return (word << bw) | bit_idx;
    endfunction

endpackage

// File: rtl/otp_seq_timer.sv
// Loadable down-counter shared by every timed sequencer state.
module otp_seq_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign expired_c = (value == '0);

endmodule

// File: rtl/otp_seq_ctrl.sv
// OTP macro sequencer: single read, per-bit program and power-up autoload.
// Define OTP_VERIFY_EN to add a read-back check after every program.
module otp_seq_ctrl
    import otp_seq_pkg::*;
#(
    parameter int unsigned ADDR_W          = 5,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned N_WORDS         = 32,
    parameter int unsigned T_SU            = T_SU_DEF,
    parameter int unsigned T_RD            = T_RD_DEF,
    parameter int unsigned T_HD            = T_HD_DEF,
    parameter int unsigned T_PG            = T_PG_DEF,
    parameter int unsigned T_VQ            = T_VQ_DEF,
    parameter bit          AUTOLOAD_ON_RST = 1'b1
) (
    input  logic                                 sys_clk,
    input  logic                                 rst,
    input  logic                                 autoload_start,
    input  logic                                 rd_req,
    input  logic                                 prog_req,
    input  logic [ADDR_W-1:0]                    req_addr,
    input  logic [DATA_W-1:0]                    prog_data,
    output logic [DATA_W-1:0]                    rd_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic                                 sh_wr,
    output logic [ADDR_W-1:0]                    sh_addr,
    output logic [DATA_W-1:0]                    sh_data,
    output logic                                 otp_csb,
    output logic                                 otp_strobe,
    output logic                                 otp_load,
    output logic                                 otp_pgenb,
    output logic                                 otp_vddqsw,
    output logic [ADDR_W+bit_idx_w(DATA_W)-1:0]  otp_addr,
    input  logic [DATA_W-1:0]                    otp_q
);

    localparam int unsigned BIT_W = bit_idx_w(DATA_W);
    localparam int unsigned OA_W  = ADDR_W + BIT_W;
    localparam int unsigned T_MAX = (T_PG > T_VQ) ? T_PG : T_VQ;
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

    logic [ST_W-1:0]   state, nxt;
    logic [ADDR_W-1:0] waddr, n_waddr;
    logic [BIT_W-1:0]  bit_sel, n_bit;
    logic [DATA_W-1:0] pend, n_pend;
    logic [DATA_W-1:0] cap, n_cap;
    logic              al_pend, n_al_pend;
    logic [DATA_W-1:0] n_rd_data, n_sh_data;
    logic [ADDR_W-1:0] n_sh_addr;
    logic [OA_W-1:0]   n_otp_addr;
    logic              n_busy, n_done, n_err, n_sh_wr;
    logic              n_csb, n_strobe, n_load, n_pgenb, n_vddqsw;
    logic              tmr_load, tmr_exp;
    logic [CNT_W-1:0]  tmr_val, tmr_value;
    logic              addr_ok_c;
`ifdef OTP_VERIFY_EN
    logic [DATA_W-1:0] pdata, n_pdata;
    logic              vfy, n_vfy;
`endif

    otp_seq_timer #(.W(CNT_W)) u_timer (
        .clk       (sys_clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .value     (tmr_value),
        .expired_c (tmr_exp)
    );

    assign addr_ok_c = (32'(req_addr) < N_WORDS);

    function automatic logic [BIT_W-1:0] low_bit(input logic [DATA_W-1:0] v);
        logic [BIT_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (v[i] && !found) begin
                r     = BIT_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Timer reload value is the entered state's length minus one.
    function automatic logic [CNT_W-1:0] dur_m1(input logic [ST_W-1:0] st);
        case (st)
            ST_RD_SU, ST_AL_SU, ST_PG_SU: return CNT_W'(T_SU - 1);
            ST_RD_STB, ST_AL_STB:         return CNT_W'(T_RD - 1);
            ST_RD_HD, ST_AL_HD:           return CNT_W'(T_HD - 1);
            ST_PG_STB:                    return CNT_W'(T_PG - 1);
            ST_PG_VQ_UP, ST_PG_VQ_DN:     return CNT_W'(T_VQ - 1);
            default:                      return '0;
        endcase
    endfunction

    always_comb begin
        nxt        = state;
        n_waddr    = waddr;
        n_bit      = bit_sel;
        n_pend     = pend;
        n_cap      = cap;
        n_al_pend  = al_pend;
        n_rd_data  = rd_data;
        n_sh_addr  = sh_addr;
        n_sh_data  = sh_data;
        n_done     = 1'b0;
        n_err      = 1'b0;
        n_sh_wr    = 1'b0;
        n_csb      = 1'b1;
        n_strobe   = 1'b0;
        n_load     = 1'b0;
        n_pgenb    = 1'b1;
        n_vddqsw   = 1'b0;
`ifdef OTP_VERIFY_EN
        n_pdata    = pdata;
        n_vfy      = vfy;
`endif
        case (state)
            ST_IDLE: begin
                if (autoload_start || al_pend) begin
                    n_al_pend = 1'b0;
                    n_waddr   = '0;
                    n_bit     = '0;
                    nxt       = ST_AL_SU;
                end else if (prog_req) begin
                    if (!addr_ok_c) begin
                        n_done = 1'b1;
                        n_err  = 1'b1;
                    end else if (prog_data == '0) begin
                        n_done = 1'b1;
                    end else begin
                        n_waddr = req_addr;
                        n_bit   = '0;
                        n_pend  = prog_data;
`ifdef OTP_VERIFY_EN
                        n_pdata = prog_data;
`endif
                        nxt     = ST_PG_VQ_UP;
                    end
                end else if (rd_req) begin
                    if (!addr_ok_c) begin
                        n_done = 1'b1;
                        n_err  = 1'b1;
                    end else begin
                        n_waddr = req_addr;
                        n_bit   = '0;
`ifdef OTP_VERIFY_EN
                        n_vfy   = 1'b0;
`endif
                        nxt     = ST_RD_SU;
                    end
                end
            end
            ST_RD_SU:  if (tmr_exp) nxt = ST_RD_STB;
            ST_AL_SU:  if (tmr_exp) nxt = ST_AL_STB;
            ST_RD_STB, ST_AL_STB: begin
                // Capture on the final strobe cycle.
                if (tmr_value == '0) n_cap = otp_q;
                if (tmr_exp) nxt = (state == ST_RD_STB) ? ST_RD_HD : ST_AL_HD;
            end
            ST_RD_HD: begin
                if (tmr_exp) begin
                    nxt       = ST_IDLE;
                    n_done    = 1'b1;
                    n_rd_data = cap;
`ifdef OTP_VERIFY_EN
                    if (vfy) n_err = ((cap & pdata) != pdata);
                    n_vfy = 1'b0;
`endif
                end
            end
            ST_AL_HD: begin
                if (tmr_exp) begin
                    nxt       = ST_AL_WR;
                    n_sh_addr = waddr;
                    n_sh_data = cap;
                end
            end
            ST_AL_WR: begin
                if (waddr == ADDR_W'(N_WORDS - 1)) begin
                    nxt    = ST_IDLE;
                    n_done = 1'b1;
                end else begin
                    n_waddr = waddr + ADDR_W'(1);
                    nxt     = ST_AL_SU;
                end
            end
            ST_PG_VQ_UP, ST_PG_NEXT: begin
                // Pick the lowest still-pending bit; zero bits never get a strobe.
                if (state == ST_PG_NEXT && pend == '0) begin
                    nxt = ST_PG_VQ_DN;
                end else if (tmr_exp) begin
                    n_bit  = low_bit(pend);
                    n_pend = pend & ~(DATA_W'(1) << low_bit(pend));
                    nxt    = ST_PG_SU;
                end
            end
            ST_PG_SU:  if (tmr_exp) nxt = ST_PG_STB;
            ST_PG_STB: if (tmr_exp) nxt = ST_PG_NEXT;
            ST_PG_VQ_DN: begin
                if (tmr_exp) begin
`ifdef OTP_VERIFY_EN
                    n_vfy  = 1'b1;
                    n_bit  = '0;
                    nxt    = ST_RD_SU;
`else
                    nxt    = ST_IDLE;
                    n_done = 1'b1;
`endif
                end
            end
            default: nxt = ST_IDLE;
        endcase

        // Macro pins follow the state being entered so they come out registered.
        case (nxt)
            ST_RD_SU, ST_RD_HD, ST_AL_SU, ST_AL_HD: begin
                n_csb  = 1'b0;
                n_load = 1'b1;
            end
            ST_RD_STB, ST_AL_STB: begin
                n_csb    = 1'b0;
                n_load   = 1'b1;
                n_strobe = 1'b1;
            end
            ST_AL_WR: begin
                n_csb   = 1'b0;
                n_load  = 1'b1;
                n_sh_wr = 1'b1;
            end
            ST_PG_VQ_UP: n_vddqsw = 1'b1;
            ST_PG_SU, ST_PG_NEXT: begin
                n_vddqsw = 1'b1;
                n_pgenb  = 1'b0;
                n_csb    = 1'b0;
            end
            ST_PG_STB: begin
                n_vddqsw = 1'b1;
                n_pgenb  = 1'b0;
                n_csb    = 1'b0;
                n_strobe = 1'b1;
            end
            default: ;
        endcase

        n_busy     = (nxt != ST_IDLE);
        n_otp_addr = OA_W'(pack_otp_addr(32'(n_waddr), 32'(n_bit), BIT_W));
        tmr_load   = (nxt != state);
        tmr_val    = dur_m1(nxt);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            waddr      <= '0;
            bit_sel    <= '0;
            pend       <= '0;
            cap        <= '0;
            al_pend    <= AUTOLOAD_ON_RST;
            rd_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sh_wr      <= 1'b0;
            sh_addr    <= '0;
            sh_data    <= '0;
            otp_csb    <= 1'b1;
            otp_strobe <= 1'b0;
            otp_load   <= 1'b0;
            otp_pgenb  <= 1'b1;
            otp_vddqsw <= 1'b0;
            otp_addr   <= '0;
`ifdef OTP_VERIFY_EN
            pdata      <= '0;
            vfy        <= 1'b0;
`endif
        end else begin
            state      <= nxt;
            waddr      <= n_waddr;
            bit_sel    <= n_bit;
            pend       <= n_pend;
            cap        <= n_cap;
            al_pend    <= n_al_pend;
            rd_data    <= n_rd_data;
            busy       <= n_busy;
            done       <= n_done;
            err        <= n_err;
            sh_wr      <= n_sh_wr;
            sh_addr    <= n_sh_addr;
            sh_data    <= n_sh_data;
            otp_csb    <= n_csb;
            otp_strobe <= n_strobe;
            otp_load   <= n_load;
            otp_pgenb  <= n_pgenb;
            otp_vddqsw <= n_vddqsw;
            otp_addr   <= n_otp_addr;
`ifdef OTP_VERIFY_EN
            pdata      <= n_pdata;
            vfy        <= n_vfy;
`endif
        end
    end

endmodule

// File: tb/tb_otp_seq_ctrl.sv
// Self-checking bench for otp_seq_ctrl: vector table, directed corner sequences
// and randomized read/program traffic against a transaction-level model.
module tb_otp_seq_ctrl;

    localparam int AW  = 6;
    localparam int DW  = 8;
    localparam int NW  = 32;
    localparam int OAW = 9;
    localparam int TSU = 2;
    localparam int TRD = 4;
    localparam int THD = 2;
    localparam int TPG = 1000;
    localparam int TVQ = 20;
`ifdef OTP_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif

    logic           sys_clk, rst, autoload_start, rd_req, prog_req;
    logic [AW-1:0]  req_addr, sh_addr;
    logic [DW-1:0]  prog_data, rd_data, sh_data, otp_q;
    logic           busy, done, err, sh_wr;
    logic           otp_csb, otp_strobe, otp_load, otp_pgenb, otp_vddqsw;
    logic [OAW-1:0] otp_addr;

    otp_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .N_WORDS(NW), .T_SU(TSU), .T_RD(TRD),
                   .T_HD(THD), .T_PG(TPG), .T_VQ(TVQ), .AUTOLOAD_ON_RST(1'b1)) dut (
        .sys_clk(sys_clk), .rst(rst), .autoload_start(autoload_start), .rd_req(rd_req),
        .prog_req(prog_req), .req_addr(req_addr), .prog_data(prog_data), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .sh_wr(sh_wr), .sh_addr(sh_addr),
        .sh_data(sh_data), .otp_csb(otp_csb), .otp_strobe(otp_strobe), .otp_load(otp_load),
        .otp_pgenb(otp_pgenb), .otp_vddqsw(otp_vddqsw), .otp_addr(otp_addr), .otp_q(otp_q)
    );

    // Macro model: word array with an optional stuck-at-0 read mask.
    logic [7:0] mem [64];
    logic [7:0] stuck;
    assign otp_q = mem[otp_addr[8:3]] & ~stuck;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_pass = 0;
    int inv_bad = 0;
    logic prev_vq = 1'b0;

    always @(negedge sys_clk) begin
        if (otp_strobe && (otp_vddqsw != prev_vq)) inv_bad = inv_bad + 1;
        if (!otp_pgenb && otp_load) inv_bad = inv_bad + 1;
        prev_vq = otp_vddqsw;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Spec-level latency from acceptance to the done pulse.
    function automatic int exp_lat(input int op, input int a, input logic [7:0] d);
        if (a >= NW) return 1;
        if (op == 0) return TSU + TRD + THD + 1;
        if (d == 8'h00) return 1;
        return 2 * TVQ + $countones(d) * (TSU + TPG + 1) + 1 + VFY * (TSU + TRD + THD);
    endfunction

    int r_lat, r_csb_low, r_vq_up;
    logic r_err, r_to;
    logic [OAW-1:0] s_addr[$];
    int s_len[$];

    // op: 0 read, 1 program, 2 read+program together. inject_rd: busy-cycle rd_req.
    task automatic run_op(input int op, input logic [AW-1:0] a, input logic [7:0] d,
                          input int inject_rd);
        int cur_len;
        r_lat = 0; r_csb_low = 0; r_vq_up = 0; r_err = 1'b0; r_to = 1'b1; cur_len = 0;
        s_addr.delete(); s_len.delete();
        req_addr  = a;
        prog_data = d;
        rd_req    = (op == 0 || op == 2);
        prog_req  = (op == 1 || op == 2);
        @(negedge sys_clk);
        rd_req = 1'b0; prog_req = 1'b0;
        for (int c = 1; c <= 20000; c++) begin
            rd_req = (c == inject_rd);
            r_lat  = c;
            if (otp_strobe) begin
                if (cur_len == 0) s_addr.push_back(otp_addr);
                cur_len++;
                if (!otp_pgenb) mem[otp_addr[8:3]] = mem[otp_addr[8:3]] | (8'd1 << otp_addr[2:0]);
            end else if (cur_len != 0) begin
                s_len.push_back(cur_len);
                cur_len = 0;
            end
            if (!otp_csb) r_csb_low++;
            if (otp_vddqsw && otp_pgenb) r_vq_up++;
            if (done) begin
                r_err = err;
                r_to  = 1'b0;
                break;
            end
            @(negedge sys_clk);
        end
        rd_req = 1'b0;
    endtask

    typedef struct {
        int         op;
        logic [5:0] addr;
        logic [7:0] pdata;
        logic [7:0] memv;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_lat;
        int         exp_stb;
        int         exp_csb;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] model_rd;

    initial begin
        int nwr, bad, csb_hi, nbusy, ndone;
        logic found, busy_at_done;
        logic [7:0] tmp, post;
        int a, nprog;

        vecs[0] = '{0, 6'd5,  8'h00, 8'h3C, 8'h3C, 1'b0, 9, 1, 8};
        vecs[1] = '{0, 6'd0,  8'h00, 8'h55, 8'h55, 1'b0, 9, 1, 8};
        vecs[2] = '{0, 6'd31, 8'h00, 8'hFF, 8'hFF, 1'b0, 9, 1, 8};
        vecs[3] = '{0, 6'd40, 8'h00, 8'h11, 8'hFF, 1'b1, 1, 0, 0};
        vecs[4] = '{0, 6'd32, 8'h00, 8'h22, 8'hFF, 1'b1, 1, 0, 0};
        vecs[5] = '{1, 6'd7,  8'h00, 8'h00, 8'hFF, 1'b0, 1, 0, 0};
        vecs[6] = '{1, 6'd33, 8'h01, 8'h00, 8'hFF, 1'b1, 1, 0, 0};

        for (int i = 0; i < 64; i++) mem[i] = 8'hA0 + 8'(i);
        stuck = 8'h00;
        rst = 1'b1; autoload_start = 1'b0; rd_req = 1'b0; prog_req = 1'b0;
        req_addr = '0; prog_data = '0;
        repeat (3) @(negedge sys_clk);

        // Reset values
        check("rst_csb", 32'(otp_csb), 32'd1);
        check("rst_pgenb", 32'(otp_pgenb), 32'd1);
        check("rst_others", 32'({busy, done, err, sh_wr, otp_strobe, otp_load, otp_vddqsw}), 32'd0);
        check("rst_data", 32'({rd_data, otp_addr}), 32'd0);

        // Autoload on reset release
        rst = 1'b0;
        nwr = 0; bad = 0; csb_hi = 0; found = 1'b0; busy_at_done = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge sys_clk);
            if (sh_wr) begin
                tmp = 8'hA0 + 8'(nwr);
                if (sh_addr !== 6'(nwr) || sh_data !== tmp) bad++;
                nwr++;
            end
            if (busy && otp_csb) csb_hi++;
            if (done) begin
                found = 1'b1;
                busy_at_done = busy;
                break;
            end
        end
        check("al_done_seen", 32'(found), 32'd1);
        check("al_wr_count", 32'(nwr), 32'd32);
        check("al_wr_content", 32'(bad), 32'd0);
        check("al_csb_low", 32'(csb_hi), 32'd0);
        check("al_busy_at_done", 32'(busy_at_done), 32'd0);
        @(negedge sys_clk);
        check("al_done_pulse", 32'(done), 32'd0);

        // Vector table
        model_rd = 8'h00;
        foreach (vecs[i]) begin
            if (vecs[i].op == 0) mem[vecs[i].addr] = vecs[i].memv;
            run_op(vecs[i].op, vecs[i].addr, vecs[i].pdata, 0);
            check($sformatf("v%0d_timeout", i), 32'(r_to), 32'd0);
            check($sformatf("v%0d_lat", i), 32'(r_lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_err", i), 32'(r_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_strobes", i), 32'(s_addr.size()), 32'(vecs[i].exp_stb));
            check($sformatf("v%0d_csb_low", i), 32'(r_csb_low), 32'(vecs[i].exp_csb));
            check($sformatf("v%0d_vq", i), 32'(r_vq_up), 32'd0);
            if (vecs[i].exp_stb != 0)
                check($sformatf("v%0d_stb_len", i), 32'((s_len.size() > 0) ? s_len[0] : 0), 32'(TRD));
            model_rd = vecs[i].exp_rd;
        end

        // Program word 3 with 1000_0101
        post = mem[3] | 8'h85;
        run_op(1, 6'd3, 8'h85, 0);
        check("pg_lat", 32'(r_lat), 32'(exp_lat(1, 3, 8'h85)));
        check("pg_err", 32'(r_err), 32'd0);
        check("pg_vq_ramp", 32'(r_vq_up), 32'(TVQ));
        check("pg_vq_off", 32'(otp_vddqsw), 32'd0);
        check("pg_nstb", 32'(s_addr.size()), 32'(3 + VFY));
        if (s_addr.size() >= 3 && s_len.size() >= 3) begin
            check("pg_stb0", 32'(s_addr[0]), 32'h18);
            check("pg_stb1", 32'(s_addr[1]), 32'h1A);
            check("pg_stb2", 32'(s_addr[2]), 32'h1F);
            check("pg_len", 32'(s_len[0] + s_len[1] + s_len[2]), 32'(3 * TPG));
        end
        if (VFY == 1) model_rd = post;
        check("pg_rd_data", 32'(rd_data), 32'(model_rd));

        // rd_req + prog_req together, plus rd_req while busy
        post = mem[9] | 8'h10;
        run_op(2, 6'd9, 8'h10, 5);
        check("both_lat", 32'(r_lat), 32'(exp_lat(1, 9, 8'h10)));
        check("both_stb", 32'((s_addr.size() > 0) ? s_addr[0] : 9'h0), 32'h4C);
        if (VFY == 1) model_rd = post;
        check("both_rd_data", 32'(rd_data), 32'(model_rd));
        nbusy = 0; ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge sys_clk);
            if (busy) nbusy++;
            if (done) ndone++;
        end
        check("drop_busy", 32'(nbusy), 32'd0);
        check("drop_done", 32'(ndone), 32'd0);

        // Reset in the middle of a program strobe
        req_addr = 6'd2; prog_data = 8'h01; prog_req = 1'b1;
        @(negedge sys_clk);
        prog_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk);
            if (otp_strobe) begin found = 1'b1; break; end
        end
        check("mid_stb_seen", 32'(found), 32'd1);
        repeat (10) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        check("mid_rst_pins", 32'({otp_vddqsw, otp_pgenb, otp_strobe, otp_csb}), 32'b0101);
        check("mid_rst_status", 32'({done, busy}), 32'd0);
        rst = 1'b0;
        model_rd = 8'h00;
        found = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge sys_clk);
            if (done) begin found = 1'b1; break; end
        end
        check("mid_rst_autoload", 32'(found), 32'd1);

        // Read-back with bit 2 stuck at 0
        stuck = 8'h04;
        mem[12] = 8'h00;
        run_op(1, 6'd12, 8'h04, 0);
        check("vfy_lat", 32'(r_lat), 32'(exp_lat(1, 12, 8'h04)));
        check("vfy_err", 32'(r_err), 32'(VFY));
        if (VFY == 1) model_rd = 8'h00;
        check("vfy_rd_data", 32'(rd_data), 32'(model_rd));
        stuck = 8'h00;

        // Randomized traffic
        nprog = 0;
        for (int i = 0; i < 25; i++) begin
            a = $urandom_range(0, 39);
            if ($urandom_range(0, 7) == 0 && nprog < 3) begin
                nprog++;
                tmp  = 8'($urandom) & 8'($urandom) & 8'($urandom);
                post = mem[a] | tmp;
                run_op(1, 6'(a), tmp, 0);
                check("rnd_pg_lat", 32'(r_lat), 32'(exp_lat(1, a, tmp)));
                check("rnd_pg_err", 32'(r_err), 32'(a >= NW));
                if (a < NW) begin
                    if (VFY == 1 && tmp != 8'h00) model_rd = post;
                    check("rnd_pg_rd_data", 32'(rd_data), 32'(model_rd));
                    run_op(0, 6'(a), 8'h00, 0);
                    model_rd = post;
                    check("rnd_pg_readback", 32'(rd_data), 32'(post));
                end
            end else begin
                mem[a] = 8'($urandom);
                run_op(0, 6'(a), 8'h00, 0);
                if (a < NW) model_rd = mem[a];
                check("rnd_rd_lat", 32'(r_lat), 32'(exp_lat(0, a, 8'h00)));
                check("rnd_rd_err", 32'(r_err), 32'(a >= NW));
                check("rnd_rd_data", 32'(rd_data), 32'(model_rd));
            end
        end

        check("invariants", 32'(inv_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
